// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_HELD,
        ST_RELEASE_DB
    } kp_state_t;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_ONE,
        FR_MULTI
    } frame_kind_t;

    // Ceiling log2, never below 1 so that it can size a vector.
    function automatic int code_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Press/release debounce FSM with optional auto-repeat, advanced once per scan frame.
//   state         | meaning
//   ST_IDLE       | no key accepted, waiting for a single closed key
//   ST_PRESS_DB   | candidate seen, counting identical frames toward acceptance
//   ST_HELD       | key accepted, key_held high, repeat timer running
//   ST_RELEASE_DB | candidate gone, counting frames toward release
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int CODE_W       = 4,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_done,
    input  logic [1:0]        frame_kind,
    input  logic [CODE_W-1:0] frame_code,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_held,
    output logic              key_release
);

    localparam logic [15:0] DB_LOAD   = 16'(DEBOUNCE - 1);
    localparam logic [15:0] RPT_DELAY = 16'(REPEAT_DELAY);
    localparam logic [15:0] RPT_RATE  = 16'(REPEAT_RATE);
    localparam bit          DB_SINGLE = (DEBOUNCE <= 1);
    localparam bit          RPT_EN    = (REPEAT_DELAY != 0);

    kp_state_t         state;
    logic [CODE_W-1:0] cand;
    logic [15:0]       db_left;
    logic [15:0]       rpt_left;
    logic              is_one;
    logic              is_multi;
    logic              same;

    assign is_one   = (frame_kind == FR_ONE);
    assign is_multi = (frame_kind == FR_MULTI);
    assign same     = is_one && (frame_code == cand);

    // Down-counters terminate at 1 and are always reloaded there, so they never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cand        <= '0;
            db_left     <= '0;
            rpt_left    <= '0;
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_held    <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            if (frame_done) begin
                case (state)
                    ST_IDLE: begin
                        if (is_one) begin
                            cand <= frame_code;
                            if (DB_SINGLE) begin
                                state     <= ST_HELD;
                                key_valid <= 1'b1;
                                key_code  <= frame_code;
                                key_held  <= 1'b1;
                                rpt_left  <= RPT_DELAY;
                            end else begin
                                state   <= ST_PRESS_DB;
                                db_left <= DB_LOAD;
                            end
                        end
                    end
                    ST_PRESS_DB: begin
                        if (same) begin
                            if (db_left <= 16'd1) begin
                                state     <= ST_HELD;
                                key_valid <= 1'b1;
                                key_code  <= cand;
                                key_held  <= 1'b1;
                                rpt_left  <= RPT_DELAY;
                            end else begin
                                db_left <= db_left - 16'd1;
                            end
                        end else if (is_one) begin
                            cand    <= frame_code;
                            db_left <= DB_LOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_HELD: begin
                        if (same || is_multi) begin
                            if (RPT_EN) begin
                                if (rpt_left <= 16'd1) begin
                                    key_valid <= 1'b1;
                                    rpt_left  <= RPT_RATE;
                                end else begin
                                    rpt_left <= rpt_left - 16'd1;
                                end
                            end
                        end else if (DB_SINGLE) begin
                            state       <= ST_IDLE;
                            key_release <= 1'b1;
                            key_held    <= 1'b0;
                        end else begin
                            state   <= ST_RELEASE_DB;
                            db_left <= DB_LOAD;
                        end
                    end
                    ST_RELEASE_DB: begin
                        if (same) begin
                            state <= ST_HELD;
                        end else if (!is_multi) begin
                            if (db_left <= 16'd1) begin
                                state       <= ST_IDLE;
                                key_release <= 1'b1;
                                key_held    <= 1'b0;
                            end else begin
                                db_left <= db_left - 16'd1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive, row synchroniser, per-frame classifier feeding the debouncer.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int  ROWS         = 4,
    parameter int  COLS         = 4,
    parameter int  SCAN_DIV     = 1000,
    parameter int  DEBOUNCE     = 4,
    parameter int  REPEAT_DELAY = 0,
    parameter int  REPEAT_RATE  = 8,
    localparam int CODE_W       = code_width(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_held,
    output logic              key_release
);

    localparam int DIV_W = code_width(SCAN_DIV);
    localparam int COL_W = code_width(COLS);

    logic [DIV_W-1:0]  slot_cnt;
    logic [COL_W-1:0]  col_idx;
    logic              slot_last;
    logic [ROWS-1:0]   row_s1;
    logic [ROWS-1:0]   row_s2;
    logic              smp_p1;
    logic              smp_p2;
    logic [COL_W-1:0]  col_p1;
    logic [COL_W-1:0]  col_p2;
    logic [1:0]        acc_hits;
    logic [CODE_W-1:0] acc_code;
    logic [1:0]        col_hits;
    logic [CODE_W-1:0] hit_code;
    logic [2:0]        sum;
    logic [1:0]        total;
    logic [CODE_W-1:0] next_code;
    logic              frame_done;
    frame_kind_t       frame_kind;

    assign slot_last = (slot_cnt == DIV_W'(SCAN_DIV - 1));

    always_comb begin
        for (int c = 0; c < COLS; c++) col[c] = (col_idx != COL_W'(c));
    end

    // The slot-end row value needs two cycles to leave the synchroniser, so the
    // sample strobe and its column index ride a matching two-stage pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt <= '0;
            col_idx  <= '0;
            row_s1   <= '1;
            row_s2   <= '1;
            smp_p1   <= 1'b0;
            smp_p2   <= 1'b0;
            col_p1   <= '0;
            col_p2   <= '0;
            acc_hits <= '0;
            acc_code <= '0;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            smp_p1 <= slot_last;
            smp_p2 <= smp_p1;
            col_p1 <= col_idx;
            col_p2 <= col_p1;
            if (slot_last) begin
                slot_cnt <= '0;
                col_idx  <= (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + COL_W'(1);
            end else begin
                slot_cnt <= slot_cnt + DIV_W'(1);
            end
            if (smp_p2) begin
                if (frame_done) begin
                    acc_hits <= '0;
                    acc_code <= '0;
                end else begin
                    acc_hits <= total;
                    acc_code <= next_code;
                end
            end
        end
    end

    always_comb begin
        col_hits = 2'd0;
        hit_code = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!row_s2[r]) begin
                if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
                hit_code = CODE_W'(r * COLS) + CODE_W'(col_p2);
            end
        end
        sum        = {1'b0, acc_hits} + {1'b0, col_hits};
        total      = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        next_code  = (col_hits == 2'd1) ? hit_code : acc_code;
        frame_done = smp_p2 && (col_p2 == COL_W'(COLS - 1));
        frame_kind = (total == 2'd0) ? FR_NONE : ((total == 2'd1) ? FR_ONE : FR_MULTI);
    end

    keypad_debounce #(
        .CODE_W       (CODE_W),
        .DEBOUNCE     (DEBOUNCE),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .frame_done  (frame_done),
        .frame_kind  (frame_kind),
        .frame_code  (next_code),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_held    (key_held),
        .key_release (key_release)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: three builds (4x4 base, 4x4 auto-repeat, 3x5) on one clock.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys_a = '0;
    logic [15:0] keys_b = '0;
    logic [14:0] keys_c = '0;
    logic [3:0]  row_a, row_b;
    logic [2:0]  row_c;
    logic [3:0]  col_a, col_b;
    logic [4:0]  col_c;
    logic        valid_a, held_a, rel_a;
    logic        valid_b, held_b, rel_b;
    logic        valid_c, held_c, rel_c;
    logic [3:0]  code_a, code_b, code_c;

    int nchk  = 0;
    int nfail = 0;
    int cyc   = 0;
    int overlap = 0;
    int va_cyc[$], va_code[$], ra_cyc[$];
    int vb_cyc[$], vb_code[$], rb_cyc[$];
    int vc_cyc[$], vc_code[$];

    always #5 clk = ~clk;

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(2), .DEBOUNCE(3), .REPEAT_DELAY(0), .REPEAT_RATE(8)) u_a (
        .clk(clk), .rst(rst), .row(row_a), .col(col_a), .key_valid(valid_a),
        .key_code(code_a), .key_held(held_a), .key_release(rel_a));

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(2), .DEBOUNCE(3), .REPEAT_DELAY(4), .REPEAT_RATE(2)) u_b (
        .clk(clk), .rst(rst), .row(row_b), .col(col_b), .key_valid(valid_b),
        .key_code(code_b), .key_held(held_b), .key_release(rel_b));

    keypad_scanner #(.ROWS(3), .COLS(5), .SCAN_DIV(2), .DEBOUNCE(3), .REPEAT_DELAY(0), .REPEAT_RATE(8)) u_c (
        .clk(clk), .rst(rst), .row(row_c), .col(col_c), .key_valid(valid_c),
        .key_code(code_c), .key_held(held_c), .key_release(rel_c));

    // Keypad model: a closed key pulls its row low while its column is driven low.
    always_comb begin
        row_a = '1;
        row_b = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (!col_a[c] && keys_a[r*4+c]) row_a[r] = 1'b0;
                if (!col_b[c] && keys_b[r*4+c]) row_b[r] = 1'b0;
            end
    end

    always_comb begin
        row_c = '1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++)
                if (!col_c[c] && keys_c[r*5+c]) row_c[r] = 1'b0;
    end

    // cyc equals k throughout cycle k, cycle 0 being the one that starts at reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (valid_a) begin va_cyc.push_back(cyc); va_code.push_back(int'(code_a)); end
        if (rel_a)   ra_cyc.push_back(cyc);
        if (valid_b) begin vb_cyc.push_back(cyc); vb_code.push_back(int'(code_b)); end
        if (rel_b)   rb_cyc.push_back(cyc);
        if (valid_c) begin vc_cyc.push_back(cyc); vc_code.push_back(int'(code_c)); end
        if ((valid_a && rel_a) || (valid_b && rel_b) || (valid_c && rel_c)) overlap++;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        va_cyc.delete(); va_code.delete(); ra_cyc.delete();
        vb_cyc.delete(); vb_code.delete(); rb_cyc.delete();
        vc_cyc.delete(); vc_code.delete();
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int k);
        int guard;
        guard = 0;
        while (cyc < k && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        nchk++;
        if (cyc < k) begin
            nfail++;
            $display("FAIL wait_timeout cyc=%0d target=%0d", cyc, k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nchk += 6;
        if (col_a !== 4'b1110) begin nfail++; $display("FAIL reset_col got %b want 1110", col_a); end
        if (valid_a !== 1'b0)  begin nfail++; $display("FAIL reset_valid got %b want 0", valid_a); end
        if (code_a !== 4'd0)   begin nfail++; $display("FAIL reset_code got %0d want 0", code_a); end
        if (held_a !== 1'b0)   begin nfail++; $display("FAIL reset_held got %b want 0", held_a); end
        if (rel_a !== 1'b0)    begin nfail++; $display("FAIL reset_release got %b want 0", rel_a); end
        if (col_c !== 5'b11110) begin nfail++; $display("FAIL reset_col35 got %b want 11110", col_c); end
    endtask

    task automatic test_scan();
        logic [3:0] exp4 [5];
        logic [4:0] exp5 [6];
        exp4 = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        exp5 = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111, 5'b11110};
        keys_a = '0; keys_b = '0; keys_c = '0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wait_cyc(2 * i);
            if (i < 5) begin
                nchk++;
                if (col_a !== exp4[i]) begin nfail++; $display("FAIL scan_col4[%0d] got %b want %b", i, col_a, exp4[i]); end
            end
            nchk++;
            if (col_c !== exp5[i]) begin nfail++; $display("FAIL scan_col5[%0d] got %b want %b", i, col_c, exp5[i]); end
        end
    endtask

    task automatic test_single_press();
        keys_a = 16'h0200;
        do_reset();
        wait_cyc(30);
        nchk += 2;
        if (held_a !== 1'b1) begin nfail++; $display("FAIL press_held got %b want 1", held_a); end
        if (code_a !== 4'd9) begin nfail++; $display("FAIL press_code got %0d want 9", code_a); end
        wait_cyc(40);
        keys_a = '0;
        wait_cyc(100);
        nchk += 3;
        if (va_cyc.size() != 1) begin nfail++; $display("FAIL press_valid_count got %0d want 1", va_cyc.size()); end
        else begin
            if (va_cyc[0] != 26) begin nfail++; $display("FAIL press_valid_cycle got %0d want 26", va_cyc[0]); end
            if (va_code[0] != 9) begin nfail++; $display("FAIL press_valid_code got %0d want 9", va_code[0]); end
        end
        nchk += 2;
        if (ra_cyc.size() != 1) begin nfail++; $display("FAIL press_release_count got %0d want 1", ra_cyc.size()); end
        else if (ra_cyc[0] != 66) begin nfail++; $display("FAIL press_release_cycle got %0d want 66", ra_cyc[0]); end
        if (held_a !== 1'b0) begin nfail++; $display("FAIL press_held_after got %b want 0", held_a); end
    endtask

    task automatic test_bounce();
        keys_a = 16'h0001;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_cyc(24 * i);
            keys_a = 16'h0001;
            wait_cyc(24 * i + 16);
            keys_a = '0;
        end
        wait_cyc(120);
        nchk += 2;
        if (va_cyc.size() != 0) begin nfail++; $display("FAIL bounce_valid_count got %0d want 0", va_cyc.size()); end
        if (ra_cyc.size() != 0) begin nfail++; $display("FAIL bounce_release_count got %0d want 0", ra_cyc.size()); end
    endtask

    task automatic test_multi();
        keys_a = 16'h0020;
        do_reset();
        wait_cyc(32);
        keys_a = 16'h0060;
        wait_cyc(60);
        nchk += 2;
        if (held_a !== 1'b1) begin nfail++; $display("FAIL multi_held got %b want 1", held_a); end
        if (code_a !== 4'd5) begin nfail++; $display("FAIL multi_code got %0d want 5", code_a); end
        wait_cyc(64);
        keys_a = 16'h0040;
        wait_cyc(130);
        nchk++;
        if (va_cyc.size() != 2) begin nfail++; $display("FAIL multi_valid_count got %0d want 2", va_cyc.size()); end
        else begin
            nchk += 4;
            if (va_cyc[0] != 26)  begin nfail++; $display("FAIL multi_valid0_cycle got %0d want 26", va_cyc[0]); end
            if (va_code[0] != 5)  begin nfail++; $display("FAIL multi_valid0_code got %0d want 5", va_code[0]); end
            if (va_cyc[1] != 114) begin nfail++; $display("FAIL multi_valid1_cycle got %0d want 114", va_cyc[1]); end
            if (va_code[1] != 6)  begin nfail++; $display("FAIL multi_valid1_code got %0d want 6", va_code[1]); end
        end
        nchk++;
        if (ra_cyc.size() != 1) begin nfail++; $display("FAIL multi_release_count got %0d want 1", ra_cyc.size()); end
        else begin
            nchk++;
            if (ra_cyc[0] != 90) begin nfail++; $display("FAIL multi_release_cycle got %0d want 90", ra_cyc[0]); end
        end
    endtask

    task automatic test_repeat();
        int exp_cyc [5];
        exp_cyc = '{26, 58, 74, 90, 106};
        keys_a = '0;
        keys_b = 16'h8000;
        do_reset();
        wait_cyc(112);
        keys_b = '0;
        wait_cyc(150);
        nchk++;
        if (vb_cyc.size() != 5) begin nfail++; $display("FAIL repeat_valid_count got %0d want 5", vb_cyc.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                nchk += 2;
                if (vb_cyc[i] != exp_cyc[i]) begin nfail++; $display("FAIL repeat_cycle[%0d] got %0d want %0d", i, vb_cyc[i], exp_cyc[i]); end
                if (vb_code[i] != 15) begin nfail++; $display("FAIL repeat_code[%0d] got %0d want 15", i, vb_code[i]); end
            end
        end
        nchk++;
        if (rb_cyc.size() != 1) begin nfail++; $display("FAIL repeat_release_count got %0d want 1", rb_cyc.size()); end
        else begin
            nchk++;
            if (rb_cyc[0] != 138) begin nfail++; $display("FAIL repeat_release_cycle got %0d want 138", rb_cyc[0]); end
        end
    endtask

    task automatic test_reset_in_hold();
        keys_a = 16'h0200;
        do_reset();
        wait_cyc(40);
        nchk++;
        if (held_a !== 1'b1) begin nfail++; $display("FAIL rsthold_pre_held got %b want 1", held_a); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        nchk += 5;
        if (held_a !== 1'b0)   begin nfail++; $display("FAIL rsthold_held got %b want 0", held_a); end
        if (valid_a !== 1'b0)  begin nfail++; $display("FAIL rsthold_valid got %b want 0", valid_a); end
        if (code_a !== 4'd0)   begin nfail++; $display("FAIL rsthold_code got %0d want 0", code_a); end
        if (rel_a !== 1'b0)    begin nfail++; $display("FAIL rsthold_release got %b want 0", rel_a); end
        if (col_a !== 4'b1110) begin nfail++; $display("FAIL rsthold_col got %b want 1110", col_a); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nchk++;
        if (col_a !== 4'b1110) begin nfail++; $display("FAIL rsthold_first_col got %b want 1110", col_a); end
        wait_cyc(30);
        nchk += 2;
        if (ra_cyc.size() != 0) begin nfail++; $display("FAIL rsthold_release_count got %0d want 0", ra_cyc.size()); end
        if (va_cyc.size() != 2) begin nfail++; $display("FAIL rsthold_valid_count got %0d want 2", va_cyc.size()); end
        else begin
            nchk++;
            if (va_cyc[1] != 26) begin nfail++; $display("FAIL rsthold_repress_cycle got %0d want 26", va_cyc[1]); end
        end
        keys_a = '0;
    endtask

    task automatic test_3x5();
        keys_c = 15'h4000;
        do_reset();
        wait_cyc(40);
        nchk += 2;
        if (held_c !== 1'b1)    begin nfail++; $display("FAIL k35_held got %b want 1", held_c); end
        if (vc_cyc.size() != 1) begin nfail++; $display("FAIL k35_valid_count got %0d want 1", vc_cyc.size()); end
        else begin
            nchk += 2;
            if (vc_cyc[0] != 32)  begin nfail++; $display("FAIL k35_valid_cycle got %0d want 32", vc_cyc[0]); end
            if (vc_code[0] != 14) begin nfail++; $display("FAIL k35_valid_code got %0d want 14", vc_code[0]); end
        end
        keys_c = '0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_single_press();
        test_bounce();
        test_multi();
        test_repeat();
        test_reset_in_hold();
        test_3x5();
        nchk++;
        if (overlap != 0) begin nfail++; $display("FAIL valid_release_overlap got %0d want 0", overlap); end
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter ROWS, default 4: number of matrix rows (2..8).
REQ-002 Parameter COLS, default 4: number of matrix columns (2..8).
REQ-003 Parameter SCAN_DIV, default 1000: clk cycles per column slot (>=2).
REQ-004 Parameter DEBOUNCE, default 4: consecutive identical frames needed to accept a press or a release (>=1).
REQ-005 Parameter REPEAT_DELAY, default 0: frames held before the first auto-repeat; 0 disables auto-repeat.
REQ-006 Parameter REPEAT_RATE, default 8: frames between auto-repeats (>=1).
REQ-007 clk  in  1  single clock; all logic rising-edge.
REQ-008 rst  in  1  reset; asynchronous, active-high.
REQ-009 row  in  ROWS  row sense lines, active-low; bit r low = key at (r, driven column) closed.
REQ-010 col  out  COLS  column drive, one-cold, active-low.
REQ-011 key_valid  out  1  one-cycle pulse per accepted press or auto-repeat.
REQ-012 key_code  out  CODE_W = clog2(ROWS*COLS)  code = row*COLS + col; stable from key_valid until the next key_valid.
REQ-013 key_held  out  1  high while the accepted key is in HELD.
REQ-014 key_release  out  1  one-cycle pulse when an accepted release completes.

Function
REQ-015 Scan: col drives exactly one low bit; the low bit advances c -> c+1 every SCAN_DIV cycles and wraps COLS-1 -> 0.
REQ-016 row is synchronised through two flops; sampling occurs on the last cycle of each slot.
REQ-017 Frame = COLS slots; at frame end the frame result is NONE (0 closed), ONE(code) (exactly 1 closed), or MULTI (>1 closed).
REQ-018 FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
REQ-019 IDLE: ONE(k) -> PRESS_DB, candidate = k, count = 1; NONE or MULTI -> stay.
REQ-020 PRESS_DB: ONE(candidate) increments count; at count = DEBOUNCE -> HELD. ONE(other) reloads candidate, count = 1. NONE or MULTI -> IDLE.
REQ-021 Entering HELD: key_valid pulses, and key_code updates in the same cycle, one cycle after the frame-end sample; key_held rises in that cycle.
REQ-022 HELD: ONE(candidate) or MULTI -> stay (MULTI never releases or changes the code); NONE or ONE(other) -> RELEASE_DB, count = 1.
REQ-023 RELEASE_DB: NONE or ONE(other) increments count; at count = DEBOUNCE -> IDLE with a key_release pulse, and key_held falls. ONE(candidate) -> HELD with no new key_valid.
REQ-024 DEBOUNCE = 1: a single qualifying frame completes a press or release.
REQ-025 Auto-repeat (REPEAT_DELAY != 0): the HELD frame counter starts at 0 on entering HELD. key_valid pulses with an unchanged key_code at frame REPEAT_DELAY, then every REPEAT_RATE frames. The counter freezes in RELEASE_DB and restarts only on a fresh press.
REQ-026 key_valid and key_release are never high in the same cycle; at most one of them per frame.
REQ-027 Counters saturate; no wrap-around of the debounce or repeat counters.

Reset
REQ-028 rst asserted: FSM = IDLE, column index 0 (col = all-ones except bit 0 low), slot counter 0, synchronisers all-ones, key_valid = 0, key_code = 0, key_held = 0, key_release = 0.
REQ-029 rst asserted mid-press or mid-hold aborts with no key_release pulse. After deassertion the first frame starts at column 0.

Structure
REQ-030 Package keypad_pkg holds the FSM state enum, the frame-result enum (NONE/ONE/MULTI), and the CODE_W computation function.
REQ-031 Sub-module keypad_debounce holds the FSM, candidate register, debounce counter, and repeat counter; keypad_scanner holds the scan divider, column driver, synchroniser, and frame classifier.

Verification (ROWS=4, COLS=4, SCAN_DIV=2, DEBOUNCE=3, REPEAT_DELAY=0 unless stated)
REQ-032 Key (2,1) held 5 frames, then open -> one key_valid with key_code 9, asserted 1 cycle after frame 3 ends. key_release pulses 1 cycle after the 3rd open frame.
REQ-033 Key (0,0) closed for 2 frames, open 1 frame, repeated 4x -> no key_valid, no key_release.
REQ-034 Key 5 held, then key 6 also closed 4 frames (MULTI), then key 6 alone -> single key_valid code 5. MULTI causes no release. After DEBOUNCE frames of key 6 alone -> key_release, then IDLE; key 6 requires a fresh press, giving key_valid code 6 after 3 further frames.
REQ-035 REPEAT_DELAY=4, REPEAT_RATE=2; key 15 held 12 frames -> key_valid at HELD frames 0, 4, 6, 8, 10; key_code 15 throughout.
REQ-036 rst pulsed while in HELD -> outputs at reset values within the same cycle as the rst edge, no key_release pulse. col = 4'b1110 on the first post-reset cycle.
REQ-037 ROWS=3, COLS=5 build; key (2,4) pressed -> key_code 14, CODE_W = 4, col cycles through 5 one-cold values.
